dac_update_sched: RTL and testbench

- Scheduler in front of the 4-channel serial DAC loader (32-bit code bus, start strobe, fixed-length 4×16-bit shift sequence).
- Arbitrates channel-update requests from two requesters (host register port H, delay-sweep engine S) and merges masked 8-bit codes into a shadow word.
- Drives the loader's data bus and start strobe, and times the loader's sequence so that the bus never changes mid-transfer.

---
 rtl/dac_sched_pkg.sv | 36 +++
 rtl/dac_update_sched_rr_arb2.sv | 20 ++
 rtl/dac_update_sched.sv | 160 ++++++++++++++++
 tb/tb_dac_update_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC update scheduler.
// Optional statistics counters are enabled with DAC_SCHED_STATS_EN.
package dac_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CODE_W = 8;
    localparam int DATA_W = 32;

    localparam logic GRANT_HOST  = 1'b0;
    localparam logic GRANT_SWEEP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT,
        GAP
    } state_t;

    // Replace the byte lanes selected by mask, keep the rest.
    function automatic logic [DATA_W-1:0] merge_codes(
        input logic [DATA_W-1:0] old_word,
        input logic [NUM_CH-1:0] mask,
        input logic [DATA_W-1:0] code
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                res[i*CODE_W +: CODE_W] = code[i*CODE_W +: CODE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dac_update_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer (last grant) lives in the parent.
// Bit 0 is the host, bit 1 the sweep engine.
module rr_arb2
    import dac_sched_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = (i_last_grant == GRANT_SWEEP) ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/dac_update_sched.sv
// Arbitrates host/sweep DAC code updates and paces the serial loader.
// Define DAC_SCHED_STATS_EN to add the upd_cnt/coll_cnt counters.
module dac_update_sched
    import dac_sched_pkg::*;
#(
    parameter int               LOAD_CYCLES = 72,
    parameter int               MIN_GAP     = 4,
    parameter logic [CODE_W-1:0] RESET_CODE = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic [NUM_CH-1:0] h_mask,
    input  logic [DATA_W-1:0] h_code,
    output logic              h_ack,
    input  logic              s_req,
    input  logic [NUM_CH-1:0] s_mask,
    input  logic [DATA_W-1:0] s_code,
    output logic              s_ack,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_cs,
    output logic              busy,
    output logic              last_grant
`ifdef DAC_SCHED_STATS_EN
    ,
    output logic [15:0]       upd_cnt,
    output logic [15:0]       coll_cnt
`endif
);

    localparam logic [7:0] WAIT_INIT = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] GAP_INIT  = (MIN_GAP == 0) ? 8'd0 : 8'(MIN_GAP - 1);

    if (LOAD_CYCLES < 1 || LOAD_CYCLES > 255) begin : g_chk_load
        $error("LOAD_CYCLES must be in 1..255");
    end
    if (MIN_GAP < 0 || MIN_GAP > 255) begin : g_chk_gap
        $error("MIN_GAP must be in 0..255");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                r_gnt;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_shadow;
    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic [NUM_CH-1:0]   w_mask;
    logic [DATA_W-1:0]   w_code;

    assign w_req  = {s_req, h_req};
    assign w_mask = (r_gnt == GRANT_SWEEP) ? s_mask : h_mask;
    assign w_code = (r_gnt == GRANT_SWEEP) ? s_code : h_code;

    rr_arb2 u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_state_nxt = (w_mask == '0) ? IDLE : START;
            end
            START: begin
                w_cnt_nxt   = WAIT_INIT;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == 8'd0) begin
                    if (MIN_GAP == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = GAP_INIT;
                        w_state_nxt = GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            GAP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shadow only moves on the LATCH edge, so it is stable for the whole load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= GRANT_HOST;
            r_last_grant <= GRANT_SWEEP;
            r_shadow     <= {NUM_CH{RESET_CODE}};
        end else begin
            if (r_state == IDLE && (|w_req)) begin
                r_gnt <= (w_gnt == 2'b10);
            end
            if (r_state == LATCH) begin
                r_last_grant <= r_gnt;
                r_shadow     <= merge_codes(r_shadow, w_mask, w_code);
            end
        end
    end

`ifdef DAC_SCHED_STATS_EN
    logic [15:0] r_upd_cnt;
    logic [15:0] r_coll_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_cnt  <= '0;
            r_coll_cnt <= '0;
        end else begin
            if (r_state == START) begin
                r_upd_cnt <= r_upd_cnt + 16'd1;
            end
            if (r_state == IDLE && h_req && s_req) begin
                r_coll_cnt <= r_coll_cnt + 16'd1;
            end
        end
    end

    assign upd_cnt  = r_upd_cnt;
    assign coll_cnt = r_coll_cnt;
`endif

    assign h_ack      = (r_state == LATCH) && (r_gnt == GRANT_HOST);
    assign s_ack      = (r_state == LATCH) && (r_gnt == GRANT_SWEEP);
    assign dac_cs     = (r_state == START);
    assign busy       = (r_state != IDLE);
    assign dac_data   = r_shadow;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_dac_update_sched.sv
// Bench for dac_update_sched: directed scenarios plus randomized traffic
// checked every cycle against a transaction-schedule model.
module tb_dac_update_sched;

    localparam int          L        = 72;
    localparam int          G        = 4;
    localparam logic [31:0] RST_DATA = 32'h80808080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_req = 1'b0;
    logic [3:0]  h_mask = '0;
    logic [31:0] h_code = '0;
    logic        s_req = 1'b0;
    logic [3:0]  s_mask = '0;
    logic [31:0] s_code = '0;
    logic        h_ack, s_ack, dac_cs, busy, last_grant;
    logic [31:0] dac_data;
`ifdef DAC_SCHED_STATS_EN
    logic [15:0] upd_cnt, coll_cnt;
`endif

    dac_update_sched dut (
        .clk        (clk),
        .rst        (rst),
        .h_req      (h_req),
        .h_mask     (h_mask),
        .h_code     (h_code),
        .h_ack      (h_ack),
        .s_req      (s_req),
        .s_mask     (s_mask),
        .s_code     (s_code),
        .s_ack      (s_ack),
        .dac_data   (dac_data),
        .dac_cs     (dac_cs),
        .busy       (busy),
        .last_grant (last_grant)
`ifdef DAC_SCHED_STATS_EN
        ,
        .upd_cnt    (upd_cnt),
        .coll_cnt   (coll_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: each service is a schedule anchored at the cycle its grant is made.
    int          cyc     = 0;
    int          m_gc    = -1000;
    int          m_per   = 2;
    logic        m_gs    = 1'b0;
    logic        m_last  = 1'b1;
    logic [31:0] m_data  = RST_DATA;
    logic [15:0] m_upd   = '0;
    logic [15:0] m_coll  = '0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [3:0] mask,
                                          input logic [31:0] code);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (mask[i]) r[i*8 +: 8] = code[i*8 +: 8];
        return r;
    endfunction

    function automatic bit m_busy(input int c);
        return (c >= m_gc + 1) && (c < m_gc + m_per);
    endfunction

    task automatic model_step();
        logic [3:0] mk;
        if (rst) begin
            started = 1'b1;
            m_gc    = -1000;
            m_per   = 2;
            m_last  = 1'b1;
            m_data  = RST_DATA;
            m_upd   = '0;
            m_coll  = '0;
        end else begin
            if (cyc == m_gc + 2 && m_per > 2) m_upd++;
            if (cyc == m_gc + 1) begin
                mk     = m_gs ? s_mask : h_mask;
                m_data = merge(m_data, mk, m_gs ? s_code : h_code);
                m_last = m_gs;
                m_per  = (mk != 0) ? 3 + L + G : 2;
            end else if (!m_busy(cyc) && (h_req || s_req)) begin
                m_gs  = (h_req && s_req) ? ~m_last : s_req;
                m_gc  = cyc;
                m_per = 2;
                if (h_req && s_req) m_coll++;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("h_ack", h_ack, (cyc == m_gc + 1) && !m_gs);
            check("s_ack", s_ack, (cyc == m_gc + 1) && m_gs);
            check("dac_cs", dac_cs, (cyc == m_gc + 2) && (m_per > 2));
            check("busy", busy, m_busy(cyc));
            check("dac_data", dac_data, m_data);
            check("last_grant", last_grant, m_last);
`ifdef DAC_SCHED_STATS_EN
            check("upd_cnt", upd_cnt, m_upd);
            check("coll_cnt", coll_cnt, m_coll);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_auto();
        bit h_done, s_done;
        h_done = (cyc == m_gc + 2) && !m_gs;
        s_done = (cyc == m_gc + 2) && m_gs;
        if (rst) rst = 1'b0;
        else if ($urandom_range(3999) == 0) rst = 1'b1;
        if (h_done && $urandom_range(1) == 0) begin
            h_req = 1'b0;
        end else if (h_done || (!h_req && $urandom_range(7) == 0)) begin
            h_req  = 1'b1;
            h_mask = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom);
            h_code = $urandom;
        end else if (h_req && cyc != m_gc + 1) begin
            if ($urandom_range(63) == 0) h_req = 1'b0;
            else if ($urandom_range(15) == 0) h_code = $urandom;
        end
        if (s_done && $urandom_range(1) == 0) begin
            s_req = 1'b0;
        end else if (s_done || (!s_req && $urandom_range(7) == 0)) begin
            s_req  = 1'b1;
            s_mask = ($urandom_range(7) == 0) ? 4'h0 : 4'($urandom);
            s_code = $urandom;
        end else if (s_req && cyc != m_gc + 1) begin
            if ($urandom_range(63) == 0) s_req = 1'b0;
            else if ($urandom_range(15) == 0) s_code = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) step();
        check("rst_data", dac_data, 32'h80808080);
        check("rst_busy", busy, 1'b0);
        check("rst_cs", dac_cs, 1'b0);
        check("rst_last", last_grant, 1'b1);
        rst = 1'b0;

        // Single host update of channel 0.
        h_req = 1'b1; h_mask = 4'b0001; h_code = 32'h0000003C;
        step();
        check("s1_ack", h_ack, 1'b1);
        h_req = 1'b0;
        step();
        check("s1_cs", dac_cs, 1'b1);
        check("s1_data", dac_data, 32'h8080803C);
        repeat (76) step();
        check("s1_busy78", busy, 1'b1);
        step();
        check("s1_busy79", busy, 1'b0);

        // Empty mask: ack only.
        h_req = 1'b1; h_mask = 4'b0000; h_code = 32'hDEADBEEF;
        step();
        check("s4_ack", h_ack, 1'b1);
        h_req = 1'b0;
        step();
        check("s4_busy", busy, 1'b0);
        check("s4_cs", dac_cs, 1'b0);
        check("s4_data", dac_data, 32'h8080803C);
        check("s4_last", last_grant, 1'b0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Simultaneous requests: host first, sweep one period later.
        h_req = 1'b1; h_mask = 4'hF; h_code = 32'h11111111;
        s_req = 1'b1; s_mask = 4'hF; s_code = 32'h22222222;
        step();
        check("s2_hack", h_ack, 1'b1);
        check("s2_sack0", s_ack, 1'b0);
        h_req = 1'b0;
        step();
        check("s2_data1", dac_data, 32'h11111111);
        repeat (78) step();
        check("s2_sack", s_ack, 1'b1);
        s_req = 1'b0;
        step();
        check("s2_data2", dac_data, 32'h22222222);
        check("s2_last", last_grant, 1'b1);
`ifdef DAC_SCHED_STATS_EN
        check("s2_upd", upd_cnt, 16'd2);
        check("s2_coll", coll_cnt, 16'd1);
`endif
        repeat (80) step();

        // Reset in the middle of WAIT, then a held sweep request.
        h_req = 1'b1; h_mask = 4'hF; h_code = 32'hA5A5A5A5;
        step();
        h_req = 1'b0;
        step();
        repeat (31) step();
        check("s5_busy", busy, 1'b1);
        s_req = 1'b1; s_mask = 4'b0110; s_code = 32'h44332211;
        rst = 1'b1;
        step();
        check("s5_data", dac_data, 32'h80808080);
        check("s5_cs", dac_cs, 1'b0);
        check("s5_idle", busy, 1'b0);
        rst = 1'b0;
        step();
        check("s5_sack", s_ack, 1'b1);
        s_req = 1'b0;
        step();
        check("s5_merge", dac_data, 32'h80332280);
        repeat (80) step();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 20000; k++) begin
            drive_auto();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
